// File: rtl/canvas_engine_if.sv
// canvas_engine_if: pointer, control and readout signals between a host and canvas_engine
interface canvas_engine_if #(
  parameter int DIM = 28,
  parameter int PIX_W = 16
);
  localparam int AW = $clog2(DIM*DIM);
  logic frame, run, mode, clear;
  logic [9:0] x_pos, y_pos;
  logic [AW-1:0] rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic busy;
  logic [15:0] stroke_cnt;
  modport master (output frame, run, mode, clear, x_pos, y_pos, rd_addr, input rd_data, busy, stroke_cnt);
  modport slave (input frame, run, mode, clear, x_pos, y_pos, rd_addr, output rd_data, busy, stroke_cnt);
endinterface

// File: rtl/canvas_engine.sv
// canvas_engine: DIM x DIM ink canvas with frame-paced pointer strokes, clear sweep and registered readout; define CANVAS_BLUR_EN for 5-cell strokes
module canvas_engine #(
  parameter int DIM = 28,
  parameter int PIX_W = 16,
  parameter int ORIGIN_X = 96,
  parameter int ORIGIN_Y = 16,
  parameter int CELL_SHIFT = 4,
  parameter logic [PIX_W-1:0] INK = 16'h4000
)(
  input logic clk,
  input logic reset,
  canvas_engine_if.slave bus
);
  localparam int N = DIM*DIM;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(DIM);
  localparam logic [PIX_W-1:0] PMAX = '1;
`ifdef CANVAS_BLUR_EN
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam logic [2:0] LAST = 3'd0;
`endif
  typedef enum logic [1:0] {IDLE, STROKE, CLEAR} state_t;
  state_t state;
  logic [PIX_W-1:0] mem [N];
  logic init, f_d, pen;
  logic [2:0] step;
  logic [CW-1:0] row, col, tr, tc;
  logic [AW-1:0] idx, ta, wa;
  logic [9:0] dx, dy, cx, cy;
  logic on_canvas, fedge, tv, we;
  logic [PIX_W-1:0] delta, cur, nxt, wd;
  logic [PIX_W:0] sum;
  assign dx = bus.x_pos - 10'(ORIGIN_X);
  assign dy = bus.y_pos - 10'(ORIGIN_Y);
  assign cx = dx >> CELL_SHIFT;
  assign cy = dy >> CELL_SHIFT;
  assign on_canvas = bus.x_pos >= 10'(ORIGIN_X) && bus.y_pos >= 10'(ORIGIN_Y) && cx < 10'(DIM) && cy < 10'(DIM);
  assign fedge = bus.frame & ~f_d;
  // step order: centre, up, down, left, right; edge neighbours burn their cycle without writing
  always_comb begin
    tr = step == 3'd1 ? row - CW'(1) : step == 3'd2 ? row + CW'(1) : row;
    tc = step == 3'd3 ? col - CW'(1) : step == 3'd4 ? col + CW'(1) : col;
    tv = step == 3'd1 ? row != '0 : step == 3'd2 ? row != CW'(DIM-1) :
         step == 3'd3 ? col != '0 : step == 3'd4 ? col != CW'(DIM-1) : 1'b1;
    ta = AW'(tr) * AW'(DIM) + AW'(tc);
    cur = ta < AW'(N) ? mem[ta] : '0;
    delta = step == 3'd0 ? INK : INK >> 1;
    sum = {1'b0, cur} + {1'b0, delta};
    nxt = pen ? (cur > delta ? cur - delta : '0) : (sum[PIX_W] ? PMAX : sum[PIX_W-1:0]);
    we = !reset && (state == STROKE ? tv : state == CLEAR);
    wa = state == CLEAR ? idx : ta;
    wd = state == CLEAR ? '0 : nxt;
  end
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      init <= 1'b1;
      f_d <= 1'b0;
      pen <= 1'b0;
      step <= '0;
      row <= '0;
      col <= '0;
      idx <= '0;
      bus.busy <= 1'b0;
      bus.stroke_cnt <= '0;
      bus.rd_data <= '0;
    end else begin
      f_d <= bus.frame;
      bus.rd_data <= bus.rd_addr < AW'(N) ? mem[bus.rd_addr] : '0;
      case (state)
        IDLE:
          if (init || bus.clear) begin
            state <= CLEAR;
            init <= 1'b0;
            idx <= '0;
            bus.busy <= 1'b1;
          end else if (fedge && bus.run && on_canvas) begin
            state <= STROKE;
            step <= '0;
            row <= cy[CW-1:0];
            col <= cx[CW-1:0];
            pen <= bus.mode;
            bus.busy <= 1'b1;
          end
        STROKE:
          if (step == LAST) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.stroke_cnt <= bus.stroke_cnt + 16'd1;
          end else step <= step + 3'd1;
        CLEAR:
          if (idx == AW'(N-1)) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.stroke_cnt <= '0;
          end else idx <= idx + AW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule
